// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
// Accepts one op, holds the ALU inputs for SETTLE cycles, then holds the captured response until it is taken.
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_cmd,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_cmd,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_overflow,
  output logic [WIDTH-1:0] alu_operandA,
  output logic [WIDTH-1:0] alu_operandB,
  output logic [3:0]       alu_command,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carryout,
  input  logic             alu_overflow
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state, state_nx;
  logic          owner;
  logic          last_grant;
  logic          grant;
  logic          accept;
  logic          capture;
  logic          rsp_taken;
  logic [CW-1:0] count;

  // Round robin: a tie goes to the requester that did not win last time.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid && grant;
  assign accept     = (state == IDLE) && (req0_valid || req1_valid);
  assign capture    = (state == EXEC) && (count == '0);
  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) && owner;
  assign rsp_taken  = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)    state_nx = EXEC;
      EXEC:    if (capture)   state_nx = RESP;
      RESP:    if (rsp_taken) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      count        <= '0;
      alu_operandA <= '0;
      alu_operandB <= '0;
      alu_command  <= '0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        owner        <= grant;
        last_grant   <= grant;
        count        <= CW'(SETTLE - 1);
        alu_operandA <= grant ? req1_a : req0_a;
        alu_operandB <= grant ? req1_b : req0_b;
        alu_command  <= {1'b0, (grant ? req1_cmd : req0_cmd)};
      end else if ((state == EXEC) && (count != '0)) begin
        count <= count - CW'(1);
      end
      // Overflow is only meaningful for ADD (0) and SUB (1).
      if (capture) begin
        rsp_result   <= alu_result;
        rsp_zero     <= alu_zero;
        rsp_carry    <= alu_carryout;
        rsp_overflow <= alu_overflow & (alu_command[2:1] == 2'b00);
      end
    end
  end

endmodule
